// File: rtl/decoder_nbit_if.sv
// Bus bundle for the registered one-hot decoder: binary index and enable in,
// one-hot select vector out.
interface decoder_nbit_if #(
  parameter int N = 5
);
  logic [N-1:0]      a;
  logic              enable;
  logic [(1<<N)-1:0] y;

  // Driver side: supplies the index/enable and observes the select bus.
  modport master (
    output a,
    output enable,
    input  y
  );

  // Decoder side: consumes the index/enable and drives the select bus.
  modport slave (
    input  a,
    input  enable,
    output y
  );
endinterface

// File: rtl/decoder_nbit.sv
// Registered N-to-2^N one-hot decoder with enable. The select bus is taken
// straight from a flop so downstream chip/row/bank selects see a clean,
// cycle-aligned one-hot value with one clock of latency.
module decoder_nbit #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_nbit_if.slave bus
);

  localparam int W = 1 << N;

  // Binary index to one-hot; every index value is in range, so no default
  // bit pattern beyond the cleared vector is needed.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
    logic [W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] dec_p0;
  logic [W-1:0] y_p1;

  // Stage 0: combinational decode, gated to all-zero when disabled.
  always_comb begin
    dec_p0 = '0;
    if (bus.enable) begin
      dec_p0 = onehot(bus.a);
    end
  end

  // Stage 1: output register; asynchronous clear drops any pending sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1 <= '0;
    end else begin
      y_p1 <= dec_p0;
    end
  end

  assign bus.y = y_p1;

endmodule

// File: tb/tb_decoder_nbit.sv
// Testbench for decoder_nbit (N = 5): directed vectors feed a scoreboard
// queue; an independent monitor compares the registered output one cycle
// after each issued sample.
module tb_decoder_nbit;

  localparam int N = 5;
  localparam int W = 1 << N;

  logic clk;
  logic rst_n;

  decoder_nbit_if #(.N(N)) bus ();

  decoder_nbit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         issued = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #50000;
    $display("FAIL watchdog: run time exceeded 50000, required completion earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Present one sample for the next rising edge and record its expected result.
  task automatic issue(input logic [N-1:0] av, input logic en, input logic [W-1:0] exp_y);
    bus.a      = av;
    bus.enable = en;
    exp_q.push_back(exp_y);
    issued = 1'b1;
    @(posedge clk);
    #2;
    issued = 1'b0;
  endtask

  // Monitor: a sample taken at a rising edge appears on y at the following falling edge.
  initial begin
    logic         samp;
    logic [W-1:0] exp_y;
    forever begin
      @(posedge clk);
      samp = issued;
      @(negedge clk);
      if (samp) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: actual=%h required=<queued value>", bus.y);
        end else begin
          exp_y = exp_q.pop_front();
          check("y", bus.y, exp_y);
          checks++;
          if ($countones(bus.y) != ((exp_y != '0) ? 1 : 0)) begin
            failures++;
            $display("FAIL popcount: actual=%0d required=%0d", $countones(bus.y),
                     (exp_y != '0) ? 1 : 0);
          end
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.a      = 5'b00001;
    bus.enable = 1'b1;

    // 1. Reset holds y low even with a live enable and clock running.
    repeat (3) @(posedge clk);
    #2;
    check("reset_hold", bus.y, 32'h0000_0000);
    rst_n = 1'b1;
    #1;
    check("reset_release_before_edge", bus.y, 32'h0000_0000);
    issue(5'd1, 1'b1, 32'h0000_0002);

    // 2. Basic decode.
    issue(5'd0, 1'b1, 32'h0000_0001);
    issue(5'd2, 1'b1, 32'h0000_0004);

    // 3. Disable forces zero, re-enable resumes.
    issue(5'd1, 1'b0, 32'h0000_0000);
    issue(5'd1, 1'b1, 32'h0000_0002);
    issue(5'd31, 1'b0, 32'h0000_0000);

    // 4. Extremes.
    issue(5'd31, 1'b1, 32'h8000_0000);
    issue(5'd0,  1'b1, 32'h0000_0001);
    issue(5'd16, 1'b1, 32'h0001_0000);
    issue(5'd15, 1'b1, 32'h0000_8000);

    // 5. Back-to-back sweep, one new index per cycle.
    for (int i = 0; i < W; i++) begin
      issue(i[N-1:0], 1'b1, 32'h1 << i);
    end

    // 6. Asynchronous reset between edges while y = 4; pending sample is dropped.
    issue(5'd2, 1'b1, 32'h0000_0004);
    @(negedge clk);
    #1;
    check("pre_async_reset", bus.y, 32'h0000_0004);
    bus.a      = 5'd7;
    bus.enable = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", bus.y, 32'h0000_0000);
    @(posedge clk);
    #2;
    check("async_reset_pending_dropped", bus.y, 32'h0000_0000);
    rst_n = 1'b1;
    issue(5'd9, 1'b1, 32'h0000_0200);
    issue(5'd30, 1'b1, 32'h4000_0000);

    // Drain the scoreboard.
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
